cheri_tbre_lsu_port: RTL and testbench
======================================

// Module: cheri_tbre_lsu_port
// PURPOSE
// - LSU-side responder for the shared tbre/stkz engine request port (tbre_lsu_* in, lsu_tbre_* out).
// - Sits inside the LSU beside the core load/store path. Turns one engine request (word or capability) into
//   one or two 33-bit memory-bus transactions, then returns done, address-increment and response pulses.
// - Strictly one bus transaction outstanding; the core LSU has priority at request acceptance.
// PARAMETERS
// - AlignChk     1'b1  1: misaligned requests (word addr[1:0]!=0, cap addr[2:0]!=0) get an error response
//                      without any bus access. 0: addr[1:0] is forced to 0 and no check is made.
// - RespTimeout  0     cycles to wait for data_rvalid_i before a forced error response; 0 = watchdog disabled.
// PORTS
// - clk_i                  in   1   clock
// - rst_ni                 in   1   synchronous active-low reset
// - tbre_lsu_req_i         in   1   engine request; held with its ctrl/addr/wdata until lsu_tbre_req_done_o
// - tbre_lsu_is_cap_i      in   1   1: capability access (2 words), 0: single word
// - tbre_lsu_we_i          in   1   1: write, 0: read
// - tbre_lsu_addr_i        in   32  byte address
// - tbre_lsu_wdata_i       in   33  {tag, data} write data
// - core_lsu_busy_i        in   1   core LSU owns the bus; blocks acceptance in IDLE only
// - lsu_tbre_req_done_o    out  1   1-cycle pulse: request fully issued, engine may drop or change it
// - lsu_tbre_addr_incr_o   out  1   1-cycle pulse on grant of cap word 0
// - lsu_tbre_resp_valid_o  out  1   1-cycle pulse: exactly one per accepted request
// - lsu_tbre_resp_err_o    out  1   error flag, valid with resp_valid
// - lsu_tbre_resp_is_wr_o  out  1   latched we, valid with resp_valid
// - lsu_tbre_raw_lsw_o     out  33  word-0 {tag, rdata}; 0 for writes and errored words
// - data_req_o             out  1   bus request
// - data_gnt_i             in   1   bus grant
// - data_we_o              out  1   bus write enable
// - data_be_o              out  4   byte enables
// - data_addr_o            out  32  word address
// - data_wdata_o           out  33  {tag, data}
// - data_rvalid_i          in   1   bus response valid
// - data_rdata_i           in   33  {tag, data}
// - data_err_i             in   1   bus error, valid with rvalid
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, latches and watchdog cleared. Reset mid-transaction abandons it silently:
//   no resp_valid is issued, and a late rvalid arriving in IDLE is ignored.
// - FSM states: IDLE, W0_REQ, W0_RSP, W1_REQ, W1_RSP, ERR_RSP.
// - IDLE: req_i & ~core_lsu_busy_i -> latch is_cap/we/addr/wdata. Misaligned with AlignChk=1 -> pulse req_done
//   this cycle, go to ERR_RSP. Otherwise go to W0_REQ.
// - ERR_RSP: resp_valid=1, err=1, raw_lsw=0 for one cycle -> IDLE.
// - W0_REQ: data_req_o=1 with addr, we, be=4'hF, wdata held stable until grant.
//   On gnt -> W0_RSP. Same cycle: pulse req_done if word access, pulse addr_incr if cap access.
// - W0_RSP: on rvalid, capture {rdata} into raw_lsw if read and ~err, accumulate err.
//   Word access -> IDLE with resp_valid pulsed the same cycle as rvalid. Cap access -> W1_REQ.
// - W1_REQ: addr = latched addr + 4 (32-bit wrap, carry dropped). Read: be=4'hF. Cap write: be=4'h0, wdata
//   tag = latched wdata[32], data = 0 (tag-only update of word 1). On gnt pulse req_done -> W1_RSP.
// - W1_RSP: on rvalid, err |= data_err_i; resp_valid pulses the same cycle -> IDLE. Word-1 rdata is discarded.
// - Simultaneous gnt+rvalid cannot occur for the same word. req_i is not sampled outside IDLE.
// - Watchdog (RespTimeout>0): counter clears on entry to W0_RSP/W1_RSP and increments per cycle. When it reaches
//   RespTimeout: pulse resp_valid+err, go to IDLE, and drop the late rvalid.
// - resp_valid is never asserted in the same cycle as req_done of a later request; requests are never overlapped.
// CONFIGURATION
// - CHERI_TBRE_LSU_ERRSKIP_EN defined: a cap read whose word 0 returns data_err_i skips W1.
//   req_done pulses in the W0_RSP rvalid cycle, resp_valid+err pulse the same cycle, then IDLE.
// - CHERI_TBRE_LSU_ERRSKIP_EN undefined: word 1 is always issued; err is the OR of both words.
// TESTING
// - Word read 0x100, gnt after 2 cycles, rvalid rdata=33'h1_DEADBEEF: req_done on gnt, resp_valid once,
//   raw_lsw=33'h1_DEADBEEF, err=0, is_wr=0.
// - Cap write addr 0x208, wdata=33'h0_12345678: bus sees 0x208 be=F data=0x12345678 tag0, then 0x20C be=0
//   tag0. addr_incr on 1st gnt, req_done on 2nd gnt, one resp_valid, is_wr=1.
// - Cap read 0x300, word-0 data_err_i=1: ERRSKIP_EN -> single bus access, resp err=1. Undefined -> 0x304 also
//   read, err=1.
// - Cap req at 0x204, AlignChk=1: no data_req_o; req_done in the accept cycle; resp_valid+err next cycle.
// - core_lsu_busy_i=1 for 5 cycles with req_i high: no data_req_o. Accept on the cycle busy drops.
// - RespTimeout=8, no rvalid: resp_valid+err 8 cycles after grant. Later rvalid is ignored; rst_ni low in
//   W0_RSP -> outputs 0 and no response.

Source files
------------

// File: rtl/cheri_tbre_lsu_port_if.sv
// Signal bundle between the tbre/stkz engine request port, the core LSU arbitration
// input and the 33-bit memory bus, as seen by cheri_tbre_lsu_port.
// The slave modport is the LSU-side responder view; master is the environment view.
interface cheri_tbre_lsu_port_if;
    // engine request side
    logic        tbre_lsu_req_i;
    logic        tbre_lsu_is_cap_i;
    logic        tbre_lsu_we_i;
    logic [31:0] tbre_lsu_addr_i;
    logic [32:0] tbre_lsu_wdata_i;
    logic        core_lsu_busy_i;
    // engine response side
    logic        lsu_tbre_req_done_o;
    logic        lsu_tbre_addr_incr_o;
    logic        lsu_tbre_resp_valid_o;
    logic        lsu_tbre_resp_err_o;
    logic        lsu_tbre_resp_is_wr_o;
    logic [32:0] lsu_tbre_raw_lsw_o;
    // memory bus
    logic        data_req_o;
    logic        data_gnt_i;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [32:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [32:0] data_rdata_i;
    logic        data_err_i;

    modport slave (
        input  tbre_lsu_req_i, tbre_lsu_is_cap_i, tbre_lsu_we_i, tbre_lsu_addr_i,
               tbre_lsu_wdata_i, core_lsu_busy_i,
        output lsu_tbre_req_done_o, lsu_tbre_addr_incr_o, lsu_tbre_resp_valid_o,
               lsu_tbre_resp_err_o, lsu_tbre_resp_is_wr_o, lsu_tbre_raw_lsw_o,
        output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
    );

    modport master (
        output tbre_lsu_req_i, tbre_lsu_is_cap_i, tbre_lsu_we_i, tbre_lsu_addr_i,
               tbre_lsu_wdata_i, core_lsu_busy_i,
        input  lsu_tbre_req_done_o, lsu_tbre_addr_incr_o, lsu_tbre_resp_valid_o,
               lsu_tbre_resp_err_o, lsu_tbre_resp_is_wr_o, lsu_tbre_raw_lsw_o,
        input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
    );
endinterface

// File: rtl/cheri_tbre_lsu_port.sv
// LSU-side responder for the tbre/stkz engine request port. Turns one word or
// capability request into one or two 33-bit bus transactions, one outstanding at a time.
// Optional feature macro: CHERI_TBRE_LSU_ERRSKIP_EN -- a cap read whose word 0 errors
// skips the word-1 access and responds immediately.
module cheri_tbre_lsu_port #(
    parameter logic        AlignChk    = 1'b1,
    parameter int unsigned RespTimeout = 0
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    cheri_tbre_lsu_port_if.slave bus
);

    localparam int unsigned CntW = (RespTimeout > 1) ? $clog2(RespTimeout) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((RespTimeout > 0) ? (RespTimeout - 1) : 0);

    typedef enum logic [2:0] {IDLE, W0_REQ, W0_RSP, W1_REQ, W1_RSP, ERR_RSP} state_e;

    state_e          state_q;
    logic            is_cap_q, we_q, err_q;
    logic [31:0]     addr_q;
    logic [32:0]     wdata_q, raw_q;
    logic [CntW-1:0] cnt_q;
    logic            data_req_q, data_we_q;
    logic [3:0]      data_be_q;
    logic [31:0]     data_addr_q;
    logic [32:0]     data_wdata_q;

    logic        accept, misalign, gnt_w0, gnt_w1, rv_w0, rv_w1;
    logic        timeout, err_skip, w0_final;
    logic [32:0] w0_data;

    // Handshake decode; the engine pulses are Mealy on gnt/rvalid so that they land
    // in the same cycle as the bus event that causes them.
    always_comb begin
        accept   = 1'b0;
        misalign = 1'b0;
        gnt_w0   = 1'b0;
        gnt_w1   = 1'b0;
        rv_w0    = 1'b0;
        rv_w1    = 1'b0;
        timeout  = 1'b0;
        err_skip = 1'b0;
        w0_final = 1'b0;
        w0_data  = '0;

        accept = (state_q == IDLE) && bus.tbre_lsu_req_i && !bus.core_lsu_busy_i;
        if (AlignChk) begin
            misalign = bus.tbre_lsu_is_cap_i ? (bus.tbre_lsu_addr_i[2:0] != 3'b000)
                                             : (bus.tbre_lsu_addr_i[1:0] != 2'b00);
        end
        gnt_w0 = (state_q == W0_REQ) && bus.data_gnt_i;
        gnt_w1 = (state_q == W1_REQ) && bus.data_gnt_i;
        rv_w0  = (state_q == W0_RSP) && bus.data_rvalid_i;
        rv_w1  = (state_q == W1_RSP) && bus.data_rvalid_i;
        // A genuine response in the same cycle as the watchdog expiry wins.
        if (RespTimeout != 0) begin
            timeout = ((state_q == W0_RSP) || (state_q == W1_RSP)) && (cnt_q == CntLast)
                      && !bus.data_rvalid_i;
        end
`ifdef CHERI_TBRE_LSU_ERRSKIP_EN
        err_skip = is_cap_q && !we_q && bus.data_err_i;
`else
        err_skip = 1'b0;
`endif
        w0_final = rv_w0 && (!is_cap_q || err_skip);
        if (!we_q && !bus.data_err_i) begin
            w0_data = bus.data_rdata_i;
        end
    end

    // Engine-facing pulses; held low while reset is asserted so an abandoned
    // transaction can never produce a response.
    assign bus.lsu_tbre_req_done_o   = rst_ni && ((accept && misalign) || (gnt_w0 && !is_cap_q) || gnt_w1
                                       || (w0_final && is_cap_q)
                                       || (timeout && (state_q == W0_RSP) && is_cap_q));
    assign bus.lsu_tbre_addr_incr_o  = rst_ni && gnt_w0 && is_cap_q;
    assign bus.lsu_tbre_resp_valid_o = rst_ni && ((state_q == ERR_RSP) || w0_final || rv_w1 || timeout);
    assign bus.lsu_tbre_resp_err_o   = rst_ni && ((state_q == ERR_RSP) || timeout
                                       || ((w0_final || rv_w1) && (err_q || bus.data_err_i)));
    assign bus.lsu_tbre_resp_is_wr_o = bus.lsu_tbre_resp_valid_o && we_q;
    assign bus.lsu_tbre_raw_lsw_o    = !bus.lsu_tbre_resp_valid_o ? '0 : (w0_final ? w0_data : raw_q);

    assign bus.data_req_o   = data_req_q;
    assign bus.data_we_o    = data_we_q;
    assign bus.data_be_o    = data_be_q;
    assign bus.data_addr_o  = data_addr_q;
    assign bus.data_wdata_o = data_wdata_q;

    // Request FSM with registered bus outputs, request latches and response watchdog.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            is_cap_q     <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            raw_q        <= '0;
            cnt_q        <= '0;
            data_req_q   <= 1'b0;
            data_we_q    <= 1'b0;
            data_be_q    <= '0;
            data_addr_q  <= '0;
            data_wdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        is_cap_q <= bus.tbre_lsu_is_cap_i;
                        we_q     <= bus.tbre_lsu_we_i;
                        addr_q   <= {bus.tbre_lsu_addr_i[31:2], 2'b00};
                        wdata_q  <= bus.tbre_lsu_wdata_i;
                        err_q    <= 1'b0;
                        raw_q    <= '0;
                        if (misalign) begin
                            state_q <= ERR_RSP;
                        end else begin
                            state_q      <= W0_REQ;
                            data_req_q   <= 1'b1;
                            data_we_q    <= bus.tbre_lsu_we_i;
                            data_be_q    <= 4'hF;
                            data_addr_q  <= {bus.tbre_lsu_addr_i[31:2], 2'b00};
                            data_wdata_q <= bus.tbre_lsu_wdata_i;
                        end
                    end
                end
                W0_REQ: begin
                    if (bus.data_gnt_i) begin
                        data_req_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= W0_RSP;
                    end
                end
                W0_RSP: begin
                    if (bus.data_rvalid_i) begin
                        if (!we_q && !bus.data_err_i) begin
                            raw_q <= bus.data_rdata_i;
                        end
                        err_q <= err_q | bus.data_err_i;
                        if (w0_final) begin
                            state_q <= IDLE;
                        end else begin
                            // Word 1 of a cap write only carries the tag; data and byte enables are zero.
                            state_q      <= W1_REQ;
                            data_req_q   <= 1'b1;
                            data_addr_q  <= addr_q + 32'd4;
                            data_be_q    <= we_q ? 4'h0 : 4'hF;
                            data_wdata_q <= we_q ? {wdata_q[32], 32'h0} : '0;
                        end
                    end else if (timeout) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                W1_REQ: begin
                    if (bus.data_gnt_i) begin
                        data_req_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= W1_RSP;
                    end
                end
                W1_RSP: begin
                    if (bus.data_rvalid_i || timeout) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ERR_RSP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cheri_tbre_lsu_port.sv
// Directed bench for cheri_tbre_lsu_port (AlignChk=1, RespTimeout=8).
module tb_cheri_tbre_lsu_port;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    int   checks = 0;
    int   failures = 0;

    cheri_tbre_lsu_port_if bus ();

    cheri_tbre_lsu_port #(.AlignChk(1'b1), .RespTimeout(8)) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // observations collected by run_req
    int          n_done, n_incr, n_resp, n_acc, done_cyc, incr_cyc, resp_cyc, first_req_cyc, req_while_busy;
    logic        resp_err_s, resp_wr_s;
    logic [32:0] raw_s;
    logic [31:0] acc_addr [4];
    logic [3:0]  acc_be   [4];
    logic        acc_we   [4];
    logic [32:0] acc_wdata[4];
    int          gnt_cyc  [4];

    task automatic idle_inputs();
        bus.tbre_lsu_req_i = 0; bus.tbre_lsu_is_cap_i = 0; bus.tbre_lsu_we_i = 0;
        bus.tbre_lsu_addr_i = '0; bus.tbre_lsu_wdata_i = '0; bus.core_lsu_busy_i = 0;
        bus.data_gnt_i = 0; bus.data_rvalid_i = 0; bus.data_rdata_i = '0; bus.data_err_i = 0;
    endtask

    // Issues one engine request and plays the memory bus. Cycle 0 is the cycle the
    // request is first presented. Bounded at 40 cycles; runs 3 cycles past the first response.
    task automatic run_req(input logic cap, input logic we, input logic [31:0] addr, input logic [32:0] wd,
                           input int gnt_dly, input int rsp_dly, input int busy_cyc,
                           input logic [32:0] rd0, input logic [32:0] rd1, input logic e0, input logic e1);
        int bphase = 0, wcnt = 0, widx = 0, post = 0;
        n_done = 0; n_incr = 0; n_resp = 0; n_acc = 0; done_cyc = -1; incr_cyc = -1; resp_cyc = -1;
        first_req_cyc = -1; req_while_busy = 0; resp_err_s = 0; resp_wr_s = 0; raw_s = '0;
        for (int cyc = 0; cyc < 40 && post < 3; cyc++) begin
            @(posedge clk); #1;
            bus.data_gnt_i = 0; bus.data_rvalid_i = 0; bus.data_err_i = 0; bus.data_rdata_i = '0;
            bus.core_lsu_busy_i = (cyc < busy_cyc);
            if (cyc == 0) begin
                bus.tbre_lsu_req_i = 1; bus.tbre_lsu_is_cap_i = cap; bus.tbre_lsu_we_i = we;
                bus.tbre_lsu_addr_i = addr; bus.tbre_lsu_wdata_i = wd;
            end else if (n_done > 0) begin
                bus.tbre_lsu_req_i = 0;
            end
            if (bphase == 0 && bus.data_req_o) begin
                if (wcnt == gnt_dly) begin
                    bus.data_gnt_i = 1;
                    if (n_acc < 4) begin
                        acc_addr[n_acc] = bus.data_addr_o; acc_be[n_acc] = bus.data_be_o;
                        acc_we[n_acc] = bus.data_we_o; acc_wdata[n_acc] = bus.data_wdata_o;
                        gnt_cyc[n_acc] = cyc;
                    end
                    n_acc++; bphase = 1; wcnt = 0;
                end else wcnt++;
            end else if (bphase == 1) begin
                if (rsp_dly >= 0 && wcnt == rsp_dly) begin
                    bus.data_rvalid_i = 1;
                    bus.data_rdata_i = (widx == 0) ? rd0 : rd1;
                    bus.data_err_i = (widx == 0) ? e0 : e1;
                    widx++; bphase = 0; wcnt = 0;
                end else wcnt++;
            end
            #3;
            if (bus.data_req_o && bus.core_lsu_busy_i) req_while_busy++;
            if (bus.data_req_o && first_req_cyc < 0) first_req_cyc = cyc;
            if (bus.lsu_tbre_req_done_o) begin n_done++; done_cyc = cyc; end
            if (bus.lsu_tbre_addr_incr_o) begin n_incr++; incr_cyc = cyc; end
            if (n_resp > 0) post++;
            if (bus.lsu_tbre_resp_valid_o) begin
                n_resp++; resp_cyc = cyc; resp_err_s = bus.lsu_tbre_resp_err_o;
                resp_wr_s = bus.lsu_tbre_resp_is_wr_o; raw_s = bus.lsu_tbre_raw_lsw_o;
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 0;
        repeat (3) @(posedge clk);
        #4;
        checks++; if (bus.data_req_o !== 1'b0) begin failures++; $display("FAIL reset_data_req got=%b exp=0", bus.data_req_o); end
        checks++; if (bus.lsu_tbre_resp_valid_o !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", bus.lsu_tbre_resp_valid_o); end
        checks++; if (bus.lsu_tbre_req_done_o !== 1'b0) begin failures++; $display("FAIL reset_req_done got=%b exp=0", bus.lsu_tbre_req_done_o); end
        checks++; if ({bus.data_be_o, bus.data_addr_o, bus.data_wdata_o, bus.data_we_o} !== '0) begin
            failures++; $display("FAIL reset_bus_outputs be=%h addr=%h wdata=%h exp=0", bus.data_be_o, bus.data_addr_o, bus.data_wdata_o); end
        checks++; if (bus.lsu_tbre_raw_lsw_o !== 33'h0) begin failures++; $display("FAIL reset_raw got=%h exp=0", bus.lsu_tbre_raw_lsw_o); end
        @(posedge clk); #1 rst_ni = 1;
    endtask

    task automatic test_word_read();
        run_req(0, 0, 32'h100, 33'h0, 2, 0, 0, 33'h1_DEADBEEF, 33'h0, 0, 0);
        checks++; if (n_acc !== 1) begin failures++; $display("FAIL wr_rd_accesses got=%0d exp=1", n_acc); end
        checks++; if ({acc_addr[0], acc_be[0], acc_we[0]} !== {32'h100, 4'hF, 1'b0}) begin
            failures++; $display("FAIL wr_rd_bus addr=%h be=%h we=%b exp 100/F/0", acc_addr[0], acc_be[0], acc_we[0]); end
        checks++; if (gnt_cyc[0] !== 3) begin failures++; $display("FAIL wr_rd_gnt_cycle got=%0d exp=3", gnt_cyc[0]); end
        checks++; if (n_done !== 1 || done_cyc !== 3) begin failures++; $display("FAIL wr_rd_done n=%0d cyc=%0d exp 1 at 3", n_done, done_cyc); end
        checks++; if (n_resp !== 1 || resp_cyc !== 4) begin failures++; $display("FAIL wr_rd_resp n=%0d cyc=%0d exp 1 at 4", n_resp, resp_cyc); end
        checks++; if ({raw_s, resp_err_s, resp_wr_s} !== {33'h1_DEADBEEF, 1'b0, 1'b0}) begin
            failures++; $display("FAIL wr_rd_resp_data raw=%h err=%b wr=%b exp 1deadbeef/0/0", raw_s, resp_err_s, resp_wr_s); end
        checks++; if (n_incr !== 0) begin failures++; $display("FAIL wr_rd_incr got=%0d exp=0", n_incr); end
    endtask

    task automatic test_cap_write();
        run_req(1, 1, 32'h208, 33'h0_12345678, 0, 0, 0, 33'h0, 33'h0, 0, 0);
        checks++; if (n_acc !== 2) begin failures++; $display("FAIL capwr_accesses got=%0d exp=2", n_acc); end
        checks++; if ({acc_addr[0], acc_be[0], acc_we[0], acc_wdata[0]} !== {32'h208, 4'hF, 1'b1, 33'h0_12345678}) begin
            failures++; $display("FAIL capwr_w0 addr=%h be=%h we=%b wd=%h exp 208/F/1/012345678", acc_addr[0], acc_be[0], acc_we[0], acc_wdata[0]); end
        checks++; if ({acc_addr[1], acc_be[1], acc_we[1], acc_wdata[1]} !== {32'h20C, 4'h0, 1'b1, 33'h0}) begin
            failures++; $display("FAIL capwr_w1 addr=%h be=%h we=%b wd=%h exp 20c/0/1/0", acc_addr[1], acc_be[1], acc_we[1], acc_wdata[1]); end
        checks++; if (n_incr !== 1 || incr_cyc !== gnt_cyc[0]) begin failures++; $display("FAIL capwr_incr n=%0d cyc=%0d exp 1 at %0d", n_incr, incr_cyc, gnt_cyc[0]); end
        checks++; if (n_done !== 1 || done_cyc !== 3) begin failures++; $display("FAIL capwr_done n=%0d cyc=%0d exp 1 at 3", n_done, done_cyc); end
        checks++; if (n_resp !== 1 || resp_cyc !== 4 || resp_wr_s !== 1'b1 || resp_err_s !== 1'b0 || raw_s !== 33'h0) begin
            failures++; $display("FAIL capwr_resp n=%0d cyc=%0d wr=%b err=%b raw=%h exp 1/4/1/0/0", n_resp, resp_cyc, resp_wr_s, resp_err_s, raw_s); end
        // tag bit must reach word 1
        run_req(1, 1, 32'h400, 33'h1_AAAA5555, 1, 1, 0, 33'h0, 33'h0, 0, 0);
        checks++; if (acc_wdata[1] !== 33'h1_00000000 || acc_addr[1] !== 32'h404) begin
            failures++; $display("FAIL capwr_tag1_w1 wd=%h addr=%h exp 100000000/404", acc_wdata[1], acc_addr[1]); end
    endtask

    task automatic test_cap_read();
        run_req(1, 0, 32'h310, 33'h0, 0, 0, 0, 33'h0_CAFEF00D, 33'h1_11111111, 0, 0);
        checks++; if (n_acc !== 2 || acc_addr[1] !== 32'h314 || acc_be[1] !== 4'hF || acc_we[1] !== 1'b0) begin
            failures++; $display("FAIL caprd_w1 n=%0d addr=%h be=%h we=%b exp 2/314/F/0", n_acc, acc_addr[1], acc_be[1], acc_we[1]); end
        checks++; if (n_resp !== 1 || raw_s !== 33'h0_CAFEF00D || resp_err_s !== 1'b0 || resp_wr_s !== 1'b0) begin
            failures++; $display("FAIL caprd_resp n=%0d raw=%h err=%b wr=%b exp 1/0cafef00d/0/0", n_resp, raw_s, resp_err_s, resp_wr_s); end
        // word 1 error only: err set, word 0 data still returned
        run_req(1, 0, 32'h320, 33'h0, 0, 2, 0, 33'h1_0000ABCD, 33'h0, 0, 1);
        checks++; if (n_resp !== 1 || resp_err_s !== 1'b1 || raw_s !== 33'h1_0000ABCD) begin
            failures++; $display("FAIL caprd_w1err n=%0d err=%b raw=%h exp 1/1/10000abcd", n_resp, resp_err_s, raw_s); end
    endtask

    task automatic test_cap_read_err();
        run_req(1, 0, 32'h300, 33'h0, 0, 0, 0, 33'h1_55555555, 33'h0, 1, 0);
`ifdef CHERI_TBRE_LSU_ERRSKIP_EN
        checks++; if (n_acc !== 1) begin failures++; $display("FAIL caprd_err_skip_accesses got=%0d exp=1", n_acc); end
        checks++; if (n_done !== 1 || done_cyc !== resp_cyc || resp_cyc !== 2) begin
            failures++; $display("FAIL caprd_err_skip_done n=%0d done=%0d resp=%0d exp 1/2/2", n_done, done_cyc, resp_cyc); end
`else
        checks++; if (n_acc !== 2 || acc_addr[1] !== 32'h304) begin failures++; $display("FAIL caprd_err_w1 n=%0d addr=%h exp 2/304", n_acc, acc_addr[1]); end
        checks++; if (n_done !== 1 || done_cyc !== 3 || resp_cyc !== 4) begin
            failures++; $display("FAIL caprd_err_timing n=%0d done=%0d resp=%0d exp 1/3/4", n_done, done_cyc, resp_cyc); end
`endif
        checks++; if (n_resp !== 1 || resp_err_s !== 1'b1 || raw_s !== 33'h0) begin
            failures++; $display("FAIL caprd_err_resp n=%0d err=%b raw=%h exp 1/1/0", n_resp, resp_err_s, raw_s); end
    endtask

    task automatic test_misaligned();
        run_req(1, 0, 32'h204, 33'h0, 0, 0, 0, 33'h0, 33'h0, 0, 0);
        checks++; if (n_acc !== 0 || first_req_cyc !== -1) begin failures++; $display("FAIL misal_cap_bus n=%0d req_cyc=%0d exp 0/-1", n_acc, first_req_cyc); end
        checks++; if (n_done !== 1 || done_cyc !== 0) begin failures++; $display("FAIL misal_cap_done n=%0d cyc=%0d exp 1 at 0", n_done, done_cyc); end
        checks++; if (n_resp !== 1 || resp_cyc !== 1 || resp_err_s !== 1'b1 || raw_s !== 33'h0) begin
            failures++; $display("FAIL misal_cap_resp n=%0d cyc=%0d err=%b raw=%h exp 1/1/1/0", n_resp, resp_cyc, resp_err_s, raw_s); end
        run_req(0, 1, 32'h102, 33'h0_FFFF0000, 0, 0, 0, 33'h0, 33'h0, 0, 0);
        checks++; if (n_acc !== 0 || n_resp !== 1 || resp_err_s !== 1'b1 || resp_wr_s !== 1'b1) begin
            failures++; $display("FAIL misal_word n=%0d resp=%0d err=%b wr=%b exp 0/1/1/1", n_acc, n_resp, resp_err_s, resp_wr_s); end
    endtask

    task automatic test_busy();
        run_req(0, 0, 32'h104, 33'h0, 0, 0, 5, 33'h0_00C0FFEE, 33'h0, 0, 0);
        checks++; if (req_while_busy !== 0) begin failures++; $display("FAIL busy_blocked got=%0d exp=0", req_while_busy); end
        checks++; if (first_req_cyc !== 6) begin failures++; $display("FAIL busy_first_req got=%0d exp=6", first_req_cyc); end
        checks++; if (n_resp !== 1 || raw_s !== 33'h0_00C0FFEE || acc_addr[0] !== 32'h104) begin
            failures++; $display("FAIL busy_resp n=%0d raw=%h addr=%h exp 1/000c0ffee/104", n_resp, raw_s, acc_addr[0]); end
    endtask

    task automatic test_back_to_back();
        run_req(0, 1, 32'h600, 33'h1_FFFFFFFF, 0, 0, 0, 33'h0, 33'h0, 0, 0);
        checks++; if ({acc_addr[0], acc_be[0], acc_we[0], acc_wdata[0]} !== {32'h600, 4'hF, 1'b1, 33'h1_FFFFFFFF}) begin
            failures++; $display("FAIL b2b_write_bus addr=%h be=%h we=%b wd=%h", acc_addr[0], acc_be[0], acc_we[0], acc_wdata[0]); end
        checks++; if (n_resp !== 1 || resp_wr_s !== 1'b1 || raw_s !== 33'h0 || done_cyc !== 1) begin
            failures++; $display("FAIL b2b_write_resp n=%0d wr=%b raw=%h done=%0d exp 1/1/0/1", n_resp, resp_wr_s, raw_s, done_cyc); end
        run_req(0, 0, 32'h604, 33'h0, 0, 1, 0, 33'h0_76543210, 33'h0, 0, 0);
        checks++; if (n_resp !== 1 || raw_s !== 33'h0_76543210 || resp_wr_s !== 1'b0 || resp_cyc !== 3) begin
            failures++; $display("FAIL b2b_read_resp n=%0d raw=%h wr=%b cyc=%0d exp 1/076543210/0/3", n_resp, raw_s, resp_wr_s, resp_cyc); end
    endtask

    task automatic test_timeout();
        run_req(0, 0, 32'h500, 33'h0, 0, -1, 0, 33'h0, 33'h0, 0, 0);
        checks++; if (n_resp !== 1 || resp_err_s !== 1'b1 || raw_s !== 33'h0) begin
            failures++; $display("FAIL tmo_resp n=%0d err=%b raw=%h exp 1/1/0", n_resp, resp_err_s, raw_s); end
        checks++; if (resp_cyc !== gnt_cyc[0] + 8) begin failures++; $display("FAIL tmo_latency got=%0d exp=%0d", resp_cyc, gnt_cyc[0] + 8); end
        @(posedge clk); #1;
        bus.data_rvalid_i = 1; bus.data_rdata_i = 33'h1_BADBAD00; bus.data_err_i = 0;
        #3;
        checks++; if (bus.lsu_tbre_resp_valid_o !== 1'b0) begin failures++; $display("FAIL tmo_late_rvalid got=%b exp=0", bus.lsu_tbre_resp_valid_o); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        bus.tbre_lsu_req_i = 1; bus.tbre_lsu_addr_i = 32'h700;
        @(posedge clk); #1;
        bus.data_gnt_i = 1;
        #3;
        checks++; if (bus.data_req_o !== 1'b1 || bus.lsu_tbre_req_done_o !== 1'b1) begin
            failures++; $display("FAIL rstmid_grant req=%b done=%b exp 1/1", bus.data_req_o, bus.lsu_tbre_req_done_o); end
        @(posedge clk); #1;
        bus.tbre_lsu_req_i = 0; bus.data_gnt_i = 0;
        rst_ni = 0; bus.data_rvalid_i = 1; bus.data_rdata_i = 33'h0_13572468;
        #3;
        checks++; if (bus.lsu_tbre_resp_valid_o !== 1'b0 || bus.lsu_tbre_raw_lsw_o !== 33'h0) begin
            failures++; $display("FAIL rstmid_resp valid=%b raw=%h exp 0/0", bus.lsu_tbre_resp_valid_o, bus.lsu_tbre_raw_lsw_o); end
        @(posedge clk); #1;
        rst_ni = 1; bus.data_rvalid_i = 1;
        #3;
        checks++; if (bus.lsu_tbre_resp_valid_o !== 1'b0 || bus.data_req_o !== 1'b0 || bus.lsu_tbre_req_done_o !== 1'b0) begin
            failures++; $display("FAIL rstmid_after valid=%b req=%b done=%b exp 0/0/0", bus.lsu_tbre_resp_valid_o, bus.data_req_o, bus.lsu_tbre_req_done_o); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_word_read();
        test_cap_write();
        test_cap_read();
        test_cap_read_err();
        test_misaligned();
        test_busy();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
